// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned NUM_W  = 3;
   localparam int unsigned LANE_W = 2;
   localparam int unsigned HALF_W = 16;

   // Byte address that maps to RAM word 0.
   localparam logic [DATA_W-1:0] DMEM_BASE = 32'h1001_0000;

   // d_num access size/sign codes; 5-7 are illegal.
   localparam logic [NUM_W-1:0] DN_W  = 3'd0;
   localparam logic [NUM_W-1:0] DN_HS = 3'd1;
   localparam logic [NUM_W-1:0] DN_HU = 3'd2;
   localparam logic [NUM_W-1:0] DN_BS = 3'd3;
   localparam logic [NUM_W-1:0] DN_BU = 3'd4;

   // Controller state encoding.
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_CAP  = 3'd2,
      ST_WR   = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   // Request fields kept after accept; only the low half of store data is
   // needed because full-word stores go straight to the write buffer.
   typedef struct packed {
      logic              wea;
      logic [NUM_W-1:0]  num;
      logic [LANE_W-1:0] lane;
      logic [HALF_W-1:0] data;
   } req_t;

   // Misaligned half/word or illegal size code.
   function automatic logic req_bad(input logic [NUM_W-1:0]  num,
                                    input logic [LANE_W-1:0] lane);
      logic bad;
      bad = 1'b0;
      case (num)
         DN_W:         bad = (lane != 2'd0);
         DN_HS, DN_HU: bad = lane[0];
         DN_BS, DN_BU: bad = 1'b0;
         default:      bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Full-word store skips the read phase.
   function automatic logic is_word(input logic [NUM_W-1:0] num);
      return (num == DN_W);
   endfunction

endpackage

// File: rtl/dmem_lane.sv
// Lane steering: load extraction/extension and sub-word store merge.
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [DATA_W-1:0] word,
   input  logic [LANE_W-1:0] lane,
   input  logic [NUM_W-1:0]  num,
   input  logic [HALF_W-1:0] sdata,
   output logic [DATA_W-1:0] ld_val_c,
   output logic [DATA_W-1:0] st_word_c
);

   logic [4:0]        shamt_c;
   logic [HALF_W-1:0] shifted_c;
   logic [DATA_W-1:0] mask_c;
   logic [DATA_W-1:0] ins_c;

   // Little-endian lane k sits at bit 8k.
   assign shamt_c   = {lane, 3'b000};
   assign shifted_c = 16'(word >> shamt_c);

   // Select the addressed lane and sign- or zero-extend it.
   always_comb begin
      ld_val_c = '0;
      case (num)
         DN_W:    ld_val_c = word;
         DN_HS:   ld_val_c = {{16{shifted_c[15]}}, shifted_c};
         DN_HU:   ld_val_c = {16'h0000, shifted_c};
         DN_BS:   ld_val_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
         DN_BU:   ld_val_c = {24'h00_0000, shifted_c[7:0]};
         default: ld_val_c = '0;
      endcase
   end

   // Overlay store data on the read word at the addressed lane.
   always_comb begin
      mask_c = '0;
      ins_c  = '0;
      case (num)
         DN_HS, DN_HU: begin
            mask_c = 32'h0000_FFFF << shamt_c;
            ins_c  = 32'(sdata) << shamt_c;
         end
         DN_BS, DN_BU: begin
            mask_c = 32'h0000_00FF << shamt_c;
            ins_c  = 32'(sdata[7:0]) << shamt_c;
         end
         default: begin
            mask_c = '0;
            ins_c  = '0;
         end
      endcase
      st_word_c = (word & ~mask_c) | ins_c;
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: CPU byte/half/word loads and stores onto a
// word-wide single-write-enable synchronous RAM, with read-modify-write for
// sub-word stores.
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned       ADDR_W = 11,
   parameter logic [DATA_W-1:0] BASE   = DMEM_BASE
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              d_start,
   input  logic              d_wea,
   input  logic [NUM_W-1:0]  d_num,
   input  logic [DATA_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   output logic              d_busy,
   output logic              d_err,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_t            state;
   req_t              req_q;
   logic [DATA_W-1:0] offset_c;
   logic [DATA_W-1:0] ld_val_c;
   logic [DATA_W-1:0] st_word_c;
   logic              unused_c;

   // Offset from the RAM base; bits above the word index wrap silently.
   assign offset_c = d_addr - BASE;
   assign unused_c = ^offset_c[DATA_W-1:ADDR_W+2];

   // Lane logic works on RAM read data and the latched request only.
   dmem_lane u_lane (
      .word      (ram_rdata),
      .lane      (req_q.lane),
      .num       (req_q.num),
      .sdata     (req_q.data),
      .ld_val_c  (ld_val_c),
      .st_word_c (st_word_c)
   );

   // Access FSM with registered RAM strobes; ram_wdata doubles as the merge buffer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         req_q     <= '0;
         d_out     <= '0;
         d_err     <= 1'b0;
         d_busy    <= 1'b0;
         ram_en    <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= '0;
         ram_wdata <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (d_start) begin
                  req_q.wea  <= d_wea;
                  req_q.num  <= d_num;
                  req_q.lane <= offset_c[1:0];
                  req_q.data <= d_in[HALF_W-1:0];
                  d_err      <= 1'b0;
                  d_busy     <= 1'b1;
                  ram_addr   <= offset_c[ADDR_W+1:2];
                  if (req_bad(d_num, offset_c[1:0])) begin
                     state <= ST_ERR;
                  end else if (d_wea && is_word(d_num)) begin
                     state     <= ST_WR;
                     ram_en    <= 1'b1;
                     ram_we    <= 1'b1;
                     ram_wdata <= d_in;
                  end else begin
                     state  <= ST_RD;
                     ram_en <= 1'b1;
                     ram_we <= 1'b0;
                  end
               end
            end
            ST_RD: begin
               state  <= ST_CAP;
               ram_en <= 1'b0;
            end
            ST_CAP: begin
               if (req_q.wea) begin
                  state     <= ST_WR;
                  ram_en    <= 1'b1;
                  ram_we    <= 1'b1;
                  ram_wdata <= st_word_c;
               end else begin
                  state  <= ST_IDLE;
                  d_busy <= 1'b0;
                  d_out  <= ld_val_c;
               end
            end
            ST_WR: begin
               state  <= ST_IDLE;
               d_busy <= 1'b0;
               ram_en <= 1'b0;
               ram_we <= 1'b0;
            end
            ST_ERR: begin
               state  <= ST_IDLE;
               d_busy <= 1'b0;
               d_err  <= 1'b1;
               if (!req_q.wea) begin
                  d_out <= '0;
               end
            end
            default: begin
               state  <= ST_IDLE;
               d_busy <= 1'b0;
               ram_en <= 1'b0;
               ram_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed plan cases plus randomized traffic against a
// byte-level memory model.
module tb_dmem_ctrl;

   localparam int unsigned ADDR_W = 11;
   localparam logic [31:0] BASE   = 32'h1001_0000;
   localparam int          DEPTH  = 2048;

   logic              clk;
   logic              reset;
   logic              d_start;
   logic              d_wea;
   logic [2:0]        d_num;
   logic [31:0]       d_addr;
   logic [31:0]       d_in;
   logic [31:0]       d_out;
   logic              d_busy;
   logic              d_err;
   logic              ram_en;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   int checks   = 0;
   int failures = 0;

   dmem_ctrl #(.ADDR_W(ADDR_W), .BASE(BASE)) dut (
      .clk       (clk),
      .reset     (reset),
      .d_start   (d_start),
      .d_wea     (d_wea),
      .d_num     (d_num),
      .d_addr    (d_addr),
      .d_in      (d_in),
      .d_out     (d_out),
      .d_busy    (d_busy),
      .d_err     (d_err),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM with one-cycle read latency, plus access bookkeeping.
   logic [31:0]       ram [DEPTH];
   int                en_cnt  = 0;
   logic [ADDR_W-1:0] last_wa = '0;
   logic [31:0]       last_wd = '0;

   always @(posedge clk) begin
      if (ram_en) begin
         en_cnt <= en_cnt + 1;
         if (ram_we) begin
            ram[ram_addr] <= ram_wdata;
            last_wa       <= ram_addr;
            last_wd       <= ram_wdata;
         end else begin
            ram_rdata <= ram[ram_addr];
         end
      end
   end

   // Reference state: memory image and the value d_out should hold.
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] exp_dout = '0;

   // Reference behaviour of one request, from address/size rules on bytes.
   task automatic ref_access(input logic wea, input logic [2:0] num,
                             input logic [31:0] addr, input logic [31:0] data,
                             output int exp_busy, output int exp_ens,
                             output logic exp_err, output int idx);
      logic [31:0] off;
      logic [7:0]  b [4];
      int          lane, size;
      bit          legal, sgn;
      longint      v;
      off  = addr - BASE;
      idx  = int'((off / 4) % DEPTH);
      lane = int'(off % 4);
      size = (num == 0) ? 4 : (num <= 2) ? 2 : 1;
      sgn  = (num == 1) || (num == 3);
      legal = (num <= 4) && (lane % size == 0);
      if (!legal) begin
         exp_err  = 1'b1;
         exp_busy = 1;
         exp_ens  = 0;
         if (!wea) exp_dout = '0;
      end else begin
         exp_err = 1'b0;
         for (int k = 0; k < 4; k++) b[k] = ref_mem[idx][8*k +: 8];
         if (!wea) begin
            v = 0;
            for (int k = 0; k < size; k++) v = v + (longint'(b[lane+k]) << (8*k));
            if (sgn && v >= (longint'(1) << (8*size-1))) v = v - (longint'(1) << (8*size));
            exp_dout = v[31:0];
            exp_busy = 2;
            exp_ens  = 1;
         end else begin
            for (int k = 0; k < size; k++) b[lane+k] = data[8*k +: 8];
            for (int k = 0; k < 4; k++) ref_mem[idx][8*k +: 8] = b[k];
            exp_busy = (size == 4) ? 1 : 3;
            exp_ens  = (size == 4) ? 1 : 2;
         end
      end
   endtask

   // Issue one request, scramble the CPU inputs after accept, and measure.
   task automatic do_access(input logic wea, input logic [2:0] num,
                            input logic [31:0] addr, input logic [31:0] data,
                            output int busy, output int ens);
      int e0;
      @(negedge clk);
      d_start = 1'b1;
      d_wea   = wea;
      d_num   = num;
      d_addr  = addr;
      d_in    = data;
      e0      = en_cnt;
      @(posedge clk);
      #1;
      d_start = 1'b0;
      d_wea   = 1'($urandom);
      d_num   = 3'($urandom);
      d_addr  = $urandom;
      d_in    = $urandom;
      busy = 0;
      while (d_busy && busy < 20) begin
         busy++;
         @(posedge clk);
         #1;
      end
      ens = en_cnt - e0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks += 7;
      if (d_out !== 32'h0)     begin failures++; $display("FAIL reset_d_out got=%h exp=0", d_out); end
      if (d_err !== 1'b0)      begin failures++; $display("FAIL reset_d_err got=%b exp=0", d_err); end
      if (d_busy !== 1'b0)     begin failures++; $display("FAIL reset_d_busy got=%b exp=0", d_busy); end
      if (ram_en !== 1'b0)     begin failures++; $display("FAIL reset_ram_en got=%b exp=0", ram_en); end
      if (ram_we !== 1'b0)     begin failures++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
      if (ram_addr !== '0)     begin failures++; $display("FAIL reset_ram_addr got=%h exp=0", ram_addr); end
      if (ram_wdata !== 32'h0) begin failures++; $display("FAIL reset_ram_wdata got=%h exp=0", ram_wdata); end
   endtask

   task automatic test_word();
      int busy, ens, eb, ee, idx;
      logic er;
      ref_access(1'b1, 3'd0, 32'h1001_0004, 32'hDEAD_BEEF, eb, ee, er, idx);
      do_access(1'b1, 3'd0, 32'h1001_0004, 32'hDEAD_BEEF, busy, ens);
      checks += 4;
      if (busy !== 1)              begin failures++; $display("FAIL sw_busy got=%0d exp=1", busy); end
      if (last_wa !== 11'd1)       begin failures++; $display("FAIL sw_ram_addr got=%0d exp=1", last_wa); end
      if (last_wd !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_ram_wdata got=%h exp=deadbeef", last_wd); end
      if (ram[1] !== 32'hDEADBEEF) begin failures++; $display("FAIL sw_word1 got=%h exp=deadbeef", ram[1]); end
      ref_access(1'b0, 3'd0, 32'h1001_0004, 32'h0, eb, ee, er, idx);
      do_access(1'b0, 3'd0, 32'h1001_0004, 32'h0, busy, ens);
      checks += 2;
      if (busy !== 2)              begin failures++; $display("FAIL lw_busy got=%0d exp=2", busy); end
      if (d_out !== 32'hDEADBEEF)  begin failures++; $display("FAIL lw_d_out got=%h exp=deadbeef", d_out); end
   endtask

   task automatic test_subword_load();
      logic [2:0]  nums [4] = '{3'd3, 3'd4, 3'd1, 3'd2};
      logic [31:0] adrs [4] = '{32'h1001_0007, 32'h1001_0007, 32'h1001_0006, 32'h1001_0004};
      logic [31:0] exps [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};
      int busy, ens, eb, ee, idx;
      logic er;
      for (int i = 0; i < 4; i++) begin
         ref_access(1'b0, nums[i], adrs[i], 32'h0, eb, ee, er, idx);
         do_access(1'b0, nums[i], adrs[i], 32'h0, busy, ens);
         checks++;
         if (d_out !== exps[i]) begin
            failures++;
            $display("FAIL subload_%0d got=%h exp=%h", i, d_out, exps[i]);
         end
      end
   endtask

   task automatic test_rmw();
      int busy, ens, eb, ee, idx;
      logic er;
      ref_access(1'b1, 3'd4, 32'h1001_0005, 32'h0000_0011, eb, ee, er, idx);
      do_access(1'b1, 3'd4, 32'h1001_0005, 32'h0000_0011, busy, ens);
      checks += 2;
      if (busy !== 3)              begin failures++; $display("FAIL sb_busy got=%0d exp=3", busy); end
      if (ram[1] !== 32'hDEAD11EF) begin failures++; $display("FAIL sb_word1 got=%h exp=dead11ef", ram[1]); end
      ref_access(1'b1, 3'd1, 32'h1001_0006, 32'h0000_1234, eb, ee, er, idx);
      do_access(1'b1, 3'd1, 32'h1001_0006, 32'h0000_1234, busy, ens);
      checks += 2;
      if (ram[1] !== 32'h123411EF) begin failures++; $display("FAIL sh_word1 got=%h exp=123411ef", ram[1]); end
      if (d_out !== 32'h0000BEEF)  begin failures++; $display("FAIL sh_d_out_hold got=%h exp=0000beef", d_out); end
      ref_access(1'b0, 3'd0, 32'h1001_0004, 32'h0, eb, ee, er, idx);
      do_access(1'b0, 3'd0, 32'h1001_0004, 32'h0, busy, ens);
      checks++;
      if (d_out !== 32'h123411EF)  begin failures++; $display("FAIL rmw_lw got=%h exp=123411ef", d_out); end
   endtask

   task automatic test_error();
      int busy, ens, eb, ee, idx;
      logic er;
      ref_access(1'b0, 3'd0, 32'h1001_0002, 32'h0, eb, ee, er, idx);
      do_access(1'b0, 3'd0, 32'h1001_0002, 32'h0, busy, ens);
      checks += 4;
      if (busy !== 1)      begin failures++; $display("FAIL err_lw_busy got=%0d exp=1", busy); end
      if (d_err !== 1'b1)  begin failures++; $display("FAIL err_lw_d_err got=%b exp=1", d_err); end
      if (ens !== 0)       begin failures++; $display("FAIL err_lw_ram_en got=%0d exp=0", ens); end
      if (d_out !== 32'h0) begin failures++; $display("FAIL err_lw_d_out got=%h exp=0", d_out); end
      ref_access(1'b0, 3'd5, 32'h1001_0004, 32'h0, eb, ee, er, idx);
      do_access(1'b0, 3'd5, 32'h1001_0004, 32'h0, busy, ens);
      checks += 2;
      if (d_err !== 1'b1)  begin failures++; $display("FAIL err_num5_d_err got=%b exp=1", d_err); end
      if (busy !== 1)      begin failures++; $display("FAIL err_num5_busy got=%0d exp=1", busy); end
      ref_access(1'b0, 3'd0, 32'h1001_0004, 32'h0, eb, ee, er, idx);
      do_access(1'b0, 3'd0, 32'h1001_0004, 32'h0, busy, ens);
      checks += 2;
      if (d_err !== 1'b0)        begin failures++; $display("FAIL err_clear got=%b exp=0", d_err); end
      if (d_out !== 32'h123411EF) begin failures++; $display("FAIL err_clear_d_out got=%h exp=123411ef", d_out); end
      ref_access(1'b1, 3'd2, 32'h1001_0005, 32'h0000_ABCD, eb, ee, er, idx);
      do_access(1'b1, 3'd2, 32'h1001_0005, 32'h0000_ABCD, busy, ens);
      checks += 3;
      if (d_err !== 1'b1)         begin failures++; $display("FAIL err_sh_d_err got=%b exp=1", d_err); end
      if (d_out !== 32'h123411EF) begin failures++; $display("FAIL err_sh_d_out got=%h exp=123411ef", d_out); end
      if (ram[1] !== 32'h123411EF) begin failures++; $display("FAIL err_sh_word1 got=%h exp=123411ef", ram[1]); end
   endtask

   task automatic test_random();
      int busy, ens, eb, ee, idx;
      logic er, wea;
      logic [2:0]  num;
      logic [31:0] addr, data;
      // Seed words 0..7 with known data through the DUT.
      for (int w = 0; w < 8; w++) begin
         data = $urandom;
         ref_access(1'b1, 3'd0, BASE + 32'(4*w), data, eb, ee, er, idx);
         do_access(1'b1, 3'd0, BASE + 32'(4*w), data, busy, ens);
         checks++;
         if (ram[w] !== ref_mem[w]) begin
            failures++;
            $display("FAIL seed_word%0d got=%h exp=%h", w, ram[w], ref_mem[w]);
         end
      end
      for (int i = 0; i < 200; i++) begin
         wea  = 1'($urandom);
         num  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
         addr = BASE + 32'($urandom_range(0, 31));
         if ($urandom_range(0, 7) == 0) addr = addr + (32'($urandom_range(1, 3)) << (ADDR_W + 2));
         data = $urandom;
         ref_access(wea, num, addr, data, eb, ee, er, idx);
         do_access(wea, num, addr, data, busy, ens);
         checks += 5;
         if (busy !== eb)         begin failures++; $display("FAIL rnd%0d_busy got=%0d exp=%0d", i, busy, eb); end
         if (ens !== ee)          begin failures++; $display("FAIL rnd%0d_ram_en got=%0d exp=%0d", i, ens, ee); end
         if (d_err !== er)        begin failures++; $display("FAIL rnd%0d_d_err got=%b exp=%b", i, d_err, er); end
         if (d_out !== exp_dout)  begin failures++; $display("FAIL rnd%0d_d_out got=%h exp=%h", i, d_out, exp_dout); end
         if (ram[idx] !== ref_mem[idx]) begin
            failures++;
            $display("FAIL rnd%0d_word%0d got=%h exp=%h", i, idx, ram[idx], ref_mem[idx]);
         end
      end
   endtask

   task automatic test_ignore_start();
      int busy, e0, eb, ee, idx;
      logic er;
      ref_access(1'b0, 3'd0, 32'h1001_0008, 32'h0, eb, ee, er, idx);
      @(negedge clk);
      d_start = 1'b1; d_wea = 1'b0; d_num = 3'd0; d_addr = 32'h1001_0008; d_in = 32'h0;
      e0 = en_cnt;
      @(posedge clk);
      #1;
      d_start = 1'b0;
      @(negedge clk);
      d_start = 1'b1; d_wea = 1'b1; d_num = 3'd0; d_addr = 32'h1001_000C; d_in = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      d_start = 1'b0;
      busy = 1;
      while (d_busy && busy < 20) begin
         busy++;
         @(posedge clk);
         #1;
      end
      checks += 4;
      if (busy !== 2)              begin failures++; $display("FAIL ign_busy got=%0d exp=2", busy); end
      if (en_cnt - e0 !== 1)       begin failures++; $display("FAIL ign_ram_en got=%0d exp=1", en_cnt - e0); end
      if (d_out !== exp_dout)      begin failures++; $display("FAIL ign_d_out got=%h exp=%h", d_out, exp_dout); end
      if (ram[3] !== ref_mem[3])   begin failures++; $display("FAIL ign_word3 got=%h exp=%h", ram[3], ref_mem[3]); end
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      d_start = 1'b1; d_wea = 1'b1; d_num = 3'd4; d_addr = 32'h1001_0005; d_in = 32'h0000_00A5;
      @(posedge clk); #1; d_start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++;
      if (ram_we !== 1'b1) begin failures++; $display("FAIL rstwr_in_wr got=%b exp=1", ram_we); end
      #2 reset = 1'b0;
      #1;
      checks += 2;
      if (ram_we !== 1'b0) begin failures++; $display("FAIL rstwr_ram_we got=%b exp=0", ram_we); end
      if (d_busy !== 1'b0) begin failures++; $display("FAIL rstwr_busy_async got=%b exp=0", d_busy); end
      exp_dout = '0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      checks += 4;
      if (ram[1] !== ref_mem[1]) begin failures++; $display("FAIL rstwr_word1 got=%h exp=%h", ram[1], ref_mem[1]); end
      if (d_busy !== 1'b0)       begin failures++; $display("FAIL rstwr_busy got=%b exp=0", d_busy); end
      if (d_out !== 32'h0)       begin failures++; $display("FAIL rstwr_d_out got=%h exp=0", d_out); end
      if (d_err !== 1'b0)        begin failures++; $display("FAIL rstwr_d_err got=%b exp=0", d_err); end
   endtask

   initial begin
      reset   = 1'b0;
      d_start = 1'b0;
      d_wea   = 1'b0;
      d_num   = 3'd0;
      d_addr  = 32'h0;
      d_in    = 32'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      test_reset();
      test_word();
      test_subword_load();
      test_rmw();
      test_error();
      test_random();
      test_ignore_start();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Data-memory access controller directly downstream of the multicycle CPU core's data port. It consumes d_start/d_wea/d_num/d_addr/d_in and returns d_out/d_busy. It converts byte/halfword/word loads and stores into accesses on a word-wide, single-write-enable synchronous RAM. Sub-word stores use read-modify-write; loads are sign- or zero-extended.

Parameters:
ADDR_W, 11, RAM word-address width (2^11 words = 8 KB)
BASE, 32'h10010000, byte address mapped to RAM word 0

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
d_start  input  1  request strobe; accepted only while d_busy=0
d_wea  input  1  1=store, 0=load
d_num  input  3  access size/sign code (see Behaviour)
d_addr  input  32  CPU byte address
d_in  input  32  store data, right-aligned
d_out  output  32  load result, registered
d_busy  output  1  high while an access is in flight
d_err  output  1  misaligned or illegal-size flag for the last request
ram_en  output  1  RAM access enable
ram_we  output  1  RAM write enable
ram_addr  output  ADDR_W  RAM word address
ram_wdata  output  32  RAM write data
ram_rdata  input  32  RAM read data, valid one cycle after ram_en with ram_we=0

Behaviour:
- Reset is asynchronous and active-low. It is one clock, and all state uses that single clock.
- Reset values: state=IDLE, d_out=0, d_err=0, d_busy=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- d_num codes: 0 word, 1 half signed, 2 half unsigned, 3 byte signed, 4 byte unsigned.
  - Stores treat 1/2 as half and 3/4 as byte.
  - Codes 5-7 are illegal.
- Offset = d_addr - BASE. Word index = offset[ADDR_W+1:2]. Lane = offset[1:0]. Little-endian: byte k occupies bits [8k+7:8k].
- Accept on a clk edge with d_start=1 and state=IDLE:
  - Latch addr, data, num and wea.
  - Clear d_err.
  - Move to the first state.
  - d_start while d_busy=1 is ignored.
- States: IDLE, RD, CAP, WR, ERR. d_busy = (state != IDLE), taken directly from the state register.
- Load: IDLE -> RD -> CAP -> IDLE.
  - RD: ram_en=1, ram_we=0.
  - CAP: capture ram_rdata, then select and extend the lane into d_out.
  - d_busy is high for 2 cycles.
- Store word: IDLE -> WR -> IDLE. WR drives ram_en=1, ram_we=1, ram_wdata=d_in. d_busy is high for 1 cycle.
- Store byte/half: IDLE -> RD -> CAP -> WR -> IDLE.
  - CAP merges d_in[7:0] or d_in[15:0] into the read word at the lane, held in the write buffer.
  - WR writes the merged word.
  - d_busy is high for 3 cycles.
- Misaligned or illegal request: half with lane[0]=1, word with lane!=0, or num 5-7.
  - IDLE -> ERR -> IDLE.
  - No ram_en at any point.
  - d_err=1, held until the next accepted start.
  - On loads, d_out=0; on stores, d_out is unchanged.
- ram_en, ram_we, ram_addr and ram_wdata are decoded from the registered state and latched request only, never from the live CPU inputs.
- d_out holds its value until the next completing load or error load.
- Reset mid-operation: state returns to IDLE immediately and ram_we drops asynchronously. A pending write is discarded and the RAM word stays untouched.
- Address wrap: offset bits above ADDR_W+1 are ignored, with no range check.

Decomposition:
- Package dmem_pkg: d_num code constants (DN_W, DN_HS, DN_HU, DN_BS, DN_BU), state encoding constants, and BASE default.
- One combinational sub-module, dmem_lane. Inputs: word, lane, num, store data. Outputs: extended load value and merged store word.
- The FSM and registers stay in dmem_ctrl.

Test Plan:
- Reset, then sw 0x10010004 with data 0xDEADBEEF -> d_busy high 1 cycle; ram_we=1, ram_addr=1, ram_wdata=0xDEADBEEF. Then lw 0x10010004 -> d_busy high 2 cycles, d_out=0xDEADBEEF.
- Word1=0xDEADBEEF:
  - lb 0x10010007 -> 0xFFFFFFDE
  - lbu 0x10010007 -> 0x000000DE
  - lh 0x10010006 -> 0xFFFFDEAD
  - lhu 0x10010004 -> 0x0000BEEF
- sb 0x10010005 with d_in=0x00000011 -> d_busy 3 cycles, RAM word1=0xDEAD11EF. Then sh 0x10010006 with d_in=0x00001234 -> word1=0x123411EF, and lw confirms it.
- Misaligned and illegal requests, each giving d_busy 1 cycle:
  - lw 0x10010002 -> d_err=1, ram_en never high, d_out=0.
  - num=5 load -> d_err=1.
  - Next legal lw -> d_err cleared on accept.
- Second d_start pulsed during the RD state of a load -> ignored: no extra RAM access, d_out reflects the first request only.
- reset driven low during the WR state of sb -> ram_we falls before the next clk edge, the RAM word is unchanged, and d_busy=0, d_out=0, d_err=0 after release.
